// File: rtl/g_pkg.sv
// Shared definitions for the g_reduce_pipe wide-gate primitive:
// mode encodings, base-op selector, padding identity and tree sizing helpers.
package g_pkg;

  localparam logic [2:0] G_MODE_AND  = 3'd0;
  localparam logic [2:0] G_MODE_OR   = 3'd1;
  localparam logic [2:0] G_MODE_XOR  = 3'd2;
  localparam logic [2:0] G_MODE_NAND = 3'd3;
  localparam logic [2:0] G_MODE_NOR  = 3'd4;
  localparam logic [2:0] G_MODE_XNOR = 3'd5;

  // Operation applied inside every tree node; NONE marks a reserved mode.
  typedef enum logic [1:0] {
    G_OP_AND  = 2'd0,
    G_OP_OR   = 2'd1,
    G_OP_XOR  = 2'd2,
    G_OP_NONE = 2'd3
  } g_op_e;

  function automatic g_op_e g_base_op(input logic [2:0] mode);
    g_op_e op;
    case (mode)
      G_MODE_AND, G_MODE_NAND: op = G_OP_AND;
      G_MODE_OR,  G_MODE_NOR:  op = G_OP_OR;
      G_MODE_XOR, G_MODE_XNOR: op = G_OP_XOR;
      default:                 op = G_OP_NONE;
    endcase
    return op;
  endfunction

  // Padding bit for leaves beyond N_IN: must not disturb the base op.
  function automatic logic g_identity(input logic [2:0] mode);
    logic id;
    if (g_base_op(mode) == G_OP_AND) id = 1'b1;
    else                             id = 1'b0;
    return id;
  endfunction

  function automatic logic g_inverts(input logic [2:0] mode);
    logic inv;
    case (mode)
      G_MODE_NAND, G_MODE_NOR, G_MODE_XNOR: inv = 1'b1;
      default:                              inv = 1'b0;
    endcase
    return inv;
  endfunction

  function automatic logic g_reserved(input logic [2:0] mode);
    return (mode > G_MODE_XNOR);
  endfunction

  // Pipeline depth: max(1, ceil(log_radix(n))).
  function automatic int g_lat(input int n, input int radix);
    int p;
    int l;
    p = 1;
    l = 0;
    for (int i = 0; i < 7; i++) begin
      if (p < n) begin
        p = p * radix;
        l = l + 1;
      end else begin
        p = p;
      end
    end
    if (l < 1) l = 1;
    else       l = l;
    return l;
  endfunction

  function automatic int g_pow(input int b, input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  // Bit offset of tree stage k (1-based) inside the flattened stage vector.
  function automatic int g_stage_off(input int k, input int lat, input int radix);
    int off;
    off = 0;
    for (int j = 1; j < k; j++) off = off + g_pow(radix, lat - j);
    return off;
  endfunction

endpackage

// File: rtl/g_reduce_node.sv
// One tree node: combinational RADIX-input reduction with the selected base op.
module g_reduce_node
  import g_pkg::*;
#(
  parameter int RADIX = 2
) (
  input  logic [1:0]       op,
  input  logic [RADIX-1:0] in_bits,
  output logic             out_bit
);

  // Reduce the node inputs with the base operation of the carried mode.
  always_comb begin
    out_bit = 1'b0;
    case (op)
      G_OP_AND: out_bit = &in_bits;
      G_OP_OR:  out_bit = |in_bits;
      G_OP_XOR: out_bit = ^in_bits;
      default:  out_bit = 1'b0;
    endcase
  end

endmodule

// File: rtl/g_reduce_pipe.sv
// g_reduce_pipe: pipelined RADIX-ary reduction of N_IN bits to one bit with a
// per-transaction mode (AND/OR/XOR and their inversions), valid/ready on both
// sides and a global stall. Optional macro G_REDUCE_PIPE_CNT_EN adds a
// saturating count of delivered results equal to 1 (ports cnt_clr, ones_cnt).
module g_reduce_pipe
  import g_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int RADIX = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_data,
  input  logic [2:0]      in_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_data,
  output logic            out_err
`ifdef G_REDUCE_PIPE_CNT_EN
  ,
  input  logic            cnt_clr,
  output logic [15:0]     ones_cnt
`endif
);

  localparam int LAT     = g_lat(N_IN, RADIX);
  localparam int PADW    = g_pow(RADIX, LAT);
  localparam int TOT     = g_stage_off(LAT + 1, LAT, RADIX);
  localparam int OUT_IDX = TOT - 1;

  logic             advance_s;
  logic [PADW-1:0]  leaf_s;
  logic [TOT-1:0]   node_s;
  logic [TOT-1:0]   next_s;
  logic [TOT-1:0]   data_r;
  logic [LAT-1:0]   valid_r;
  logic [2:0]       mode_r [LAT];
  logic [2:0]       last_mode_s;

  assign advance_s = !valid_r[LAT-1] | out_ready;
  assign in_ready  = advance_s;
  assign out_valid = valid_r[LAT-1];
  assign out_data  = data_r[OUT_IDX];
  assign out_err   = g_reserved(mode_r[LAT-1]);

  // Pad the operand out to a full tree with the base op's identity bit.
  always_comb begin
    leaf_s            = {PADW{g_identity(in_mode)}};
    leaf_s[N_IN-1:0]  = in_data;
  end

  // Tree stages: stage k reduces groups of RADIX values from stage k-1.
  for (genvar k = 1; k <= LAT; k++) begin : g_stage
    localparam int NODES = g_pow(RADIX, LAT - k);
    localparam int OFF   = g_stage_off(k, LAT, RADIX);
    logic [1:0] op_s;
    if (k == 1) begin : g_first
      assign op_s = g_base_op(in_mode);
      for (genvar n = 0; n < NODES; n++) begin : g_node
        g_reduce_node #(.RADIX(RADIX)) u_node (
          .op      (op_s),
          .in_bits (leaf_s[n*RADIX +: RADIX]),
          .out_bit (node_s[OFF+n])
        );
      end
    end else begin : g_inner
      localparam int POFF = g_stage_off(k - 1, LAT, RADIX);
      assign op_s = g_base_op(mode_r[k-2]);
      for (genvar n = 0; n < NODES; n++) begin : g_node
        g_reduce_node #(.RADIX(RADIX)) u_node (
          .op      (op_s),
          .in_bits (data_r[POFF + n*RADIX +: RADIX]),
          .out_bit (node_s[OFF+n])
        );
      end
    end
  end

  if (LAT == 1) begin : g_last_direct
    assign last_mode_s = in_mode;
  end else begin : g_last_piped
    assign last_mode_s = mode_r[LAT-2];
  end

  // Final stage applies inversion and forces reserved modes to 0 before the output register.
  always_comb begin
    next_s = node_s;
    if (g_reserved(last_mode_s)) begin
      next_s[OUT_IDX] = 1'b0;
    end else begin
      next_s[OUT_IDX] = node_s[OUT_IDX] ^ g_inverts(last_mode_s);
    end
  end

  // Stage registers: all shift together when the output side can advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= {LAT{1'b0}};
      data_r  <= {TOT{1'b0}};
      for (int j = 0; j < LAT; j++) mode_r[j] <= 3'd0;
    end else if (advance_s) begin
      valid_r[0] <= in_valid;
      mode_r[0]  <= in_mode;
      for (int j = 1; j < LAT; j++) begin
        valid_r[j] <= valid_r[j-1];
        mode_r[j]  <= mode_r[j-1];
      end
      data_r <= next_s;
    end else begin
      valid_r <= valid_r;
      data_r  <= data_r;
    end
  end

`ifdef G_REDUCE_PIPE_CNT_EN
  logic [15:0] cnt_r;
  assign ones_cnt = cnt_r;

  // Saturating count of delivered non-error results equal to 1; clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 16'd0;
    end else if (cnt_clr) begin
      cnt_r <= 16'd0;
    end else if (out_valid && out_ready && out_data && !out_err && (cnt_r != 16'hFFFF)) begin
      cnt_r <= cnt_r + 16'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end
`else
  // Counter feature not built: no extra ports or state.
`endif

endmodule

// File: tb/tb_g_reduce_pipe.sv
// Self-checking bench for g_reduce_pipe: instance 0 (N_IN=8, RADIX=2) and
// instance 1 (N_IN=5, RADIX=4); counter checks when G_REDUCE_PIPE_CNT_EN is set.
module tb_g_reduce_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [1:0] iv, ir, ov, ordy, od, oe;
  logic [7:0] d0;
  logic [4:0] d1;
  logic [2:0] m0, m1;
`ifdef G_REDUCE_PIPE_CNT_EN
  logic        clr;
  logic [15:0] cnt0, cnt1;
`endif

  typedef struct { int c; logic [1:0] de; } beat_t;
  logic [1:0] exp0[$];
  logic [1:0] exp1[$];
  beat_t      log0[$];
  beat_t      log1[$];
  logic [1:0] held [2];
  logic [1:0] stall;

  g_reduce_pipe #(.N_IN(8), .RADIX(2)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(d0), .in_mode(m0),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_err(oe[0])
`ifdef G_REDUCE_PIPE_CNT_EN
    , .cnt_clr(1'b0), .ones_cnt(cnt0)
`endif
  );

  g_reduce_pipe #(.N_IN(5), .RADIX(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(d1), .in_mode(m1),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_err(oe[1])
`ifdef G_REDUCE_PIPE_CNT_EN
    , .cnt_clr(clr), .ones_cnt(cnt1)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: count ones over the n operand bits, then apply the mode rule.
  // Returns {data, err}.
  function automatic logic [1:0] model(input logic [7:0] d, input int n, input logic [2:0] m);
    int  ones;
    int  mi;
    logic r;
    mi = int'(m);
    if (mi > 5) return 2'b01;
    ones = 0;
    for (int i = 0; i < n; i++) ones += int'(d[i]);
    case (mi % 3)
      0:       r = (ones == n);
      1:       r = (ones != 0);
      default: r = ones[0];
    endcase
    if (mi >= 3) r = ~r;
    return {r, 1'b0};
  endfunction

  always @(posedge clk) cyc++;

  task automatic mon(input int k);
    logic [1:0] e;
    logic [1:0] got;
    beat_t b;
    got = {od[k], oe[k]};
    if (ov[k]) begin
      if (stall[k]) check($sformatf("hold_stable%0d", k), got, held[k]);
      held[k]  = got;
      stall[k] = !ordy[k];
      if (ordy[k]) begin
        if ((k == 0 ? exp0.size() : exp1.size()) == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_out%0d: got %0b expected no result", k, got);
        end else begin
          e = (k == 0) ? exp0.pop_front() : exp1.pop_front();
          check($sformatf("result%0d", k), got, e);
        end
        b.c = cyc; b.de = got;
        if (k == 0) log0.push_back(b); else log1.push_back(b);
      end
    end else begin
      stall[k] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0);
      mon(1);
    end
  end

  task automatic push(input int k, input logic [7:0] d, input logic [2:0] m);
    int g;
    g = 0;
    iv[k] = 1'b1;
    if (k == 0) begin d0 = d; m0 = m; end
    else        begin d1 = d[4:0]; m1 = m; end
    while (!ir[k] && g < 50) begin @(posedge clk); #1; g++; end
    if (g >= 50) begin
      tests++; fails++;
      $display("FAIL push_timeout%0d: in_ready stayed 0 expected 1", k);
    end
    @(posedge clk);
    if (k == 0) exp0.push_back(model(d, 8, m)); else exp1.push_back(model(d, 5, m));
    #1;
    iv[k] = 1'b0;
  endtask

  // Counts the transfer edge as cycle 1.
  task automatic wait_valid(input int k, output int n);
    n = 1;
    while (!ov[k] && n < 20) begin @(posedge clk); #1; n++; end
  endtask

  task automatic drain(input int k);
    int g;
    g = 0;
    while (((k == 0) ? exp0.size() : exp1.size()) > 0 && g < 60) begin
      @(negedge clk); #1; g++;
    end
    if (g >= 60) begin
      tests++; fails++;
      $display("FAIL drain_timeout%0d: results pending expected none", k);
    end
    @(posedge clk); #1;
  endtask

  int n;
  int s;
  logic [1:0] want4 [4];

  initial begin
    iv = 2'b00; ordy = 2'b11; d0 = 8'h00; d1 = 5'h00; m0 = 3'd0; m1 = 3'd0;
    stall = 2'b00; held[0] = 2'b00; held[1] = 2'b00;
`ifdef G_REDUCE_PIPE_CNT_EN
    clr = 1'b0;
`endif
    #12;
    check("rst_out_valid", ov, 2'b00);
    check("rst_out_data", od, 2'b00);
    check("rst_out_err", oe, 2'b00);
    rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_rst", ir, 2'b11);

    // AND latency and value
    push(0, 8'hFF, 3'd0);
    wait_valid(0, n);
    check("lat_and", n, 3);
    check("and_ff", {od[0], oe[0]}, 2'b10);
    drain(0);
    push(0, 8'hFE, 3'd0);
    wait_valid(0, n);
    check("and_fe", {od[0], oe[0]}, 2'b00);
    drain(0);

    // Streaming four modes back to back
    s = log0.size();
    push(0, 8'h01, 3'd2);
    push(0, 8'h00, 3'd4);
    push(0, 8'h03, 3'd5);
    push(0, 8'h00, 3'd1);
    drain(0);
    check("stream_count", log0.size() - s, 4);
    want4[0] = 2'b10; want4[1] = 2'b10; want4[2] = 2'b10; want4[3] = 2'b00;
    if (log0.size() >= s + 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("stream_val%0d", i), log0[s+i].de, want4[i]);
        check($sformatf("stream_cyc%0d", i), log0[s+i].c - log0[s].c, i);
      end
    end

    // Backpressure
    ordy[0] = 1'b0;
    s = log0.size();
    push(0, 8'hAA, 3'd0);
    push(0, 8'hAA, 3'd1);
    push(0, 8'h07, 3'd2);
    check("bp_in_ready_low", ir[0], 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    check("bp_out_valid", ov[0], 1'b1);
    check("bp_in_ready_still_low", ir[0], 1'b0);
    ordy[0] = 1'b1;
    drain(0);
    check("bp_count", log0.size() - s, 3);
    if (log0.size() >= s + 3) begin
      check("bp_val0", log0[s].de, 2'b00);
      check("bp_val1", log0[s+1].de, 2'b10);
      check("bp_val2", log0[s+2].de, 2'b10);
    end

    // Reserved mode then normal mode
    s = log0.size();
    push(0, 8'hFF, 3'd7);
    push(0, 8'hFF, 3'd0);
    drain(0);
    if (log0.size() >= s + 2) begin
      check("rsvd_err", log0[s].de, 2'b01);
      check("after_rsvd", log0[s+1].de, 2'b10);
    end else begin
      check("rsvd_count", log0.size() - s, 2);
    end

    // Reset with transactions in flight
    ordy[0] = 1'b0;
    push(0, 8'hF0, 3'd1);
    push(0, 8'h0F, 3'd2);
    @(posedge clk); #1;
    check("inflight_valid", ov[0], 1'b1);
    rst = 1'b1;
    #1;
    check("rst_async_valid", ov[0], 1'b0);
    exp0.delete();
    exp1.delete();
    stall = 2'b00;
    #10;
    rst = 1'b0;
    ordy[0] = 1'b1;
    s = log0.size();
    repeat (8) begin @(posedge clk); #1; end
    check("no_stale_after_rst", log0.size() - s, 0);
    check("rst_idle_valid", ov[0], 1'b0);

    // N_IN=5, RADIX=4: padding and two-stage latency
    push(1, 8'h1F, 3'd0);
    wait_valid(1, n);
    check("lat5_and", n, 2);
    check("and5_1f", {od[1], oe[1]}, 2'b10);
    drain(1);
    push(1, 8'h0F, 3'd0);
    push(1, 8'h1F, 3'd2);
    push(1, 8'h00, 3'd4);
    drain(1);
    if (log1.size() >= 4) begin
      check("and5_0f", log1[1].de, 2'b00);
      check("xor5_1f", log1[2].de, 2'b10);
      check("nor5_00", log1[3].de, 2'b10);
    end else begin
      check("n5_count", log1.size(), 4);
    end

`ifdef G_REDUCE_PIPE_CNT_EN
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("cnt_clr0", cnt1, 16'd0);
    for (int i = 0; i < 10; i++) push(1, 8'h1F, 3'd0);
    push(1, 8'h1F, 3'd6);
    push(1, 8'h00, 3'd0);
    drain(1);
    check("cnt_ten", cnt1, 16'd10);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("cnt_clr1", cnt1, 16'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/g_reduce_pipe.md
Name: g_reduce_pipe

Overview:
- Parametrised, pipelined successor to the fixed 3-input AND gate.
- Reduces an N_IN-bit input vector to one bit with a per-transaction selectable operation: AND, OR, XOR, NAND, NOR or XNOR.
- Reduction runs as a registered RADIX-ary tree behind a valid/ready handshake.
- Serves as the team's generic wide-gate primitive in FPGA datapaths.

Parameters:
- N_IN, 8, number of input bits; legal range 2..64.
- RADIX, 2, inputs combined per tree node per stage; legal values 2 or 4.
- LAT, derived as max(1, ceil(log_RADIX(N_IN))), number of pipeline stages; not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts a transaction this cycle.
- in_data  in  N_IN  operand bits.
- in_mode  in  3  operation: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 reserved.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_data  out  1  reduction result.
- out_err  out  1  result came from a reserved mode.

Behaviour:
- Reset (asynchronous, active-high): all stage valids are 0. out_valid=0, out_data=0, out_err=0. in_ready reflects the reset pipeline state, so it is 1 once rst deasserts.
- Reset asserted mid-operation discards every in-flight transaction. No partial result appears after reset.
- Handshake:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - out_data and out_err hold stable while out_valid & !out_ready.
- Global stall: advance = !out_valid | out_ready. in_ready = advance. Every stage register loads only when advance=1.
- Bubbles propagate as valid=0. A stage with valid=0 still shifts when advance=1.
- Latency: exactly LAT cycles from input transfer to out_valid when out_ready is held high.
- Throughput: one transaction per cycle when out_ready is held high.
- Mode handling:
  - in_mode is captured with in_data and carries through every stage alongside it. Back-to-back transactions may use different modes.
- Tree construction:
  - Base op is AND for modes 0/3, OR for modes 1/4, XOR for modes 2/5.
  - Leaves beyond N_IN are padded with the base op's identity: 1 for AND, 0 for OR and XOR.
  - Stage k reduces groups of RADIX values from stage k-1 and registers the results.
- Inversion: modes 3/4/5 invert the final base result in the last stage, before the output register.
- Reserved modes 6/7: out_data=0 and out_err=1 for that transaction. Otherwise out_err=0.
- Simultaneous input transfer and output transfer in the same cycle is legal and loses no data.

Optional Feature:
- Macro: G_REDUCE_PIPE_CNT_EN.
- When defined:
  - Adds output ones_cnt (16 bits) and input cnt_clr (1 bit).
  - ones_cnt increments on each output transfer whose out_data=1 and out_err=0.
  - ones_cnt saturates at 0xFFFF.
  - cnt_clr=1 zeroes the count synchronously and takes priority over an increment in the same cycle.
  - rst zeroes the count.
- When undefined: neither port exists and no counter logic is generated.

Decomposition:
- Shared package g_pkg holds:
  - Mode encoding constants: G_MODE_AND=0, G_MODE_OR=1, G_MODE_XOR=2, G_MODE_NAND=3, G_MODE_NOR=4, G_MODE_XNOR=5.
  - Function g_identity(mode), returning the padding bit.
  - Function g_base_op(mode), returning the base-op selector.
- One sub-module, g_reduce_node: combinational RADIX-input reduction for a given base op, instantiated per tree node per stage. Stage registers live in the top module.

Test Plan:
- N_IN=8, RADIX=2; in_data=8'hFF, mode AND, out_ready=1 -> out_valid after 3 cycles, out_data=1, out_err=0. Repeat with in_data=8'hFE -> out_data=0.
- Streaming, one transfer per cycle, out_ready=1:
  - XOR on 8'h01 -> 1.
  - NOR on 8'h00 -> 1.
  - XNOR on 8'h03 -> 1.
  - OR on 8'h00 -> 0.
  - Required: 4 results in order on 4 consecutive cycles, no bubbles.
- Backpressure: hold out_ready=0 for 5 cycles while 3 transactions are offered -> in_ready drops, out_data stays stable, all 3 results delivered in order once out_ready=1.
- Reserved mode 7 with in_data=8'hFF -> out_data=0, out_err=1. The next AND transaction -> out_err=0.
- Assert rst while 2 transactions are in flight -> out_valid=0 immediately. No stale result appears after rst deasserts.
- N_IN=5, RADIX=4, G_REDUCE_PIPE_CNT_EN defined:
  - AND on 5'h1F gives out_data=1 after 2 cycles, which checks padding.
  - Ten results equal to 1 -> ones_cnt=10.
  - Pulse cnt_clr -> ones_cnt=0.
